// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: data-RAM access plus registered writeback.
// Optional DMEM_CLEAR_EN: zero the RAM after reset, holding mem_busy until done.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_write,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  output logic              mem_busy,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  logic              accept;
  logic              is_store;
  logic              is_load;
  logic              hi_nz;
  logic              fault;
  logic [ADDR_W-1:0] idx;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign idx      = ex_alu_result[ADDR_W+1:2];
  // Store wins when both memory controls are set.
  assign is_store = ex_mem_write;
  assign is_load  = ex_mem_to_reg & ~ex_mem_write;
  assign accept   = ex_valid & ~mem_busy & ~rst;

  if (DATA_W > ADDR_W + 2) begin : g_hi
    assign hi_nz = |ex_alu_result[DATA_W-1:ADDR_W+2];
  end else begin : g_no_hi
    assign hi_nz = 1'b0;
  end

  assign fault = (is_store | is_load) & ((ex_alu_result[1:0] != 2'b00) | hi_nz);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign clr_we   = (state_q == StClear) & ~rst;
  assign clr_addr = clr_cnt_q;
  assign mem_busy = busy_q;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign mem_busy = 1'b0;
`endif

  always_comb begin
    mem_we    = clr_we | (accept & is_store & ~fault);
    mem_waddr = idx;
    mem_wdata = ex_write_data;
    if (clr_we) begin
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_valid <= accept;
      wb_we    <= accept & ex_reg_write & (ex_rd != '0) & ~is_store;
      mem_err  <= accept & fault;
      if (accept) begin
        wb_rd <= ex_rd;
        if (is_load) begin
          wb_data <= fault ? '0 : mem[idx];
        end else begin
          wb_data <= ex_alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage (default build): directed vector table, reset corners, and
// randomized traffic checked against a word-addressed RAM model.
module tb_mem_wb_stage;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_write_data = '0;
  logic        mem_busy;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_write  (ex_mem_write),
    .ex_rd         (ex_rd),
    .ex_alu_result (ex_alu_result),
    .ex_write_data (ex_write_data),
    .mem_busy      (mem_busy),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: RAM as a sparse word map, plus predicted outputs.
  logic [31:0] mref [int];
  logic        e_valid, e_we, e_err, e_data_known;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  typedef struct {
    logic        v, rw, m2r, mw;
    logic [4:0]  rd;
    logic [31:0] alu, wd;
    logic        x_valid, x_we, x_err, chk_data;
    logic [31:0] x_data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one slot, update the model, then advance past the accept edge.
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic mw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    logic acc, flt;
    int   widx;
    ex_valid      = v;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
    ex_mem_write  = mw;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_write_data = wd;
    acc  = m2r | mw;
    flt  = acc && ((alu % 4) != 0 || alu >= 32'(4 * DEPTH));
    widx = int'(alu / 4);
    e_valid = v;
    e_we    = v && rw && rd != 0 && !mw;
    e_err   = v && flt;
    if (v) begin
      e_rd = rd;
      if (mw) begin
        e_data_known = 1'b0;
        if (!flt) mref[widx] = wd;
      end else if (m2r) begin
        if (flt) begin
          e_data = '0;
          e_data_known = 1'b1;
        end else if (mref.exists(widx)) begin
          e_data = mref[widx];
          e_data_known = 1'b1;
        end else begin
          e_data_known = 1'b0;
        end
      end else begin
        e_data = alu;
        e_data_known = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(e_valid));
    chk({tag, ".we"},    32'(wb_we),    32'(e_we));
    chk({tag, ".err"},   32'(mem_err),  32'(e_err));
    if (e_valid) chk({tag, ".rd"}, 32'(wb_rd), 32'(e_rd));
    if (e_valid && e_data_known) chk({tag, ".data"}, wb_data, e_data);
  endtask

  initial begin
    // Directed vectors: v rw m2r mw rd alu wd | valid we err chk_data data
    tbl.push_back('{1,1,0,0, 5, 32'h0000_00AB, 32'h0,         1,1,0,1, 32'h0000_00AB});
    tbl.push_back('{1,0,0,1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 1,0,0,0, 32'h0});
    tbl.push_back('{1,1,1,0, 7, 32'h0000_0010, 32'h0,         1,1,0,1, 32'hDEAD_BEEF});
    tbl.push_back('{1,0,0,1, 0, 32'h0000_0012, 32'h1234_5678, 1,0,1,0, 32'h0});
    tbl.push_back('{1,1,0,0, 1, 32'h0000_0000, 32'h0,         1,1,0,1, 32'h0});
    tbl.push_back('{1,1,1,0, 8, 32'h0000_0010, 32'h0,         1,1,0,1, 32'hDEAD_BEEF});
    tbl.push_back('{1,1,1,0, 3, 32'h0000_1000, 32'h0,         1,1,1,1, 32'h0});
    tbl.push_back('{1,1,0,0, 0, 32'h0000_0055, 32'h0,         1,0,0,1, 32'h0000_0055});
    tbl.push_back('{0,1,0,1, 6, 32'h0000_0010, 32'hFFFF_FFFF, 0,0,0,0, 32'h0});
    tbl.push_back('{1,1,1,0, 9, 32'h0000_0010, 32'h0,         1,1,0,1, 32'hDEAD_BEEF});
    tbl.push_back('{1,1,1,1, 4, 32'h0000_0014, 32'h0BAD_F00D, 1,0,0,0, 32'h0});
    tbl.push_back('{1,1,1,0, 4, 32'h0000_0014, 32'h0,         1,1,0,1, 32'h0BAD_F00D});
    tbl.push_back('{1,1,1,0, 2, 32'h0000_0011, 32'h0,         1,1,1,1, 32'h0});
    tbl.push_back('{1,1,1,0, 2, 32'h8000_0010, 32'h0,         1,1,1,1, 32'h0});
    tbl.push_back('{1,1,0,0, 2, 32'hCAFE_0001, 32'h0,         1,1,0,1, 32'hCAFE_0001});

    // Reset held for three cycles with a live slot on the inputs.
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; ex_alu_result = 32'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(wb_valid), 32'd0);
    chk("rst.we",    32'(wb_we),    32'd0);
    chk("rst.rd",    32'(wb_rd),    32'd0);
    chk("rst.data",  wb_data,       32'd0);
    chk("rst.err",   32'(mem_err),  32'd0);
    chk("rst.busy",  32'(mem_busy), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].mw, tbl[i].rd, tbl[i].alu, tbl[i].wd);
      chk({tag, ".valid"}, 32'(wb_valid), 32'(tbl[i].x_valid));
      chk({tag, ".we"},    32'(wb_we),    32'(tbl[i].x_we));
      chk({tag, ".err"},   32'(mem_err),  32'(tbl[i].x_err));
      if (tbl[i].x_valid) chk({tag, ".rd"}, 32'(wb_rd), 32'(tbl[i].rd));
      if (tbl[i].chk_data) chk({tag, ".data"}, wb_data, tbl[i].x_data);
    end

    // Mid-stream reset drops the pending slot but keeps RAM contents.
    rst = 1'b1;
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b0; ex_mem_write = 1'b0;
    ex_rd = 5'd6; ex_alu_result = 32'h99;
    @(posedge clk);
    #1;
    chk("midrst.valid", 32'(wb_valid), 32'd0);
    chk("midrst.we",    32'(wb_we),    32'd0);
    chk("midrst.data",  wb_data,       32'd0);
    rst = 1'b0;
    drive(1, 1, 1, 0, 5'd7, 32'h10, 32'h0);
    chk("keep.data", wb_data, 32'hDEAD_BEEF);
    chk("keep.we",   32'(wb_we), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        v, rw, m2r, mw;
      logic [31:0] alu;
      int          kind, r;
      v    = ($urandom % 5) != 0;
      rw   = $urandom % 4 != 0;
      kind = $urandom % 4;
      m2r  = kind == 2 || kind == 3;
      mw   = kind == 1 || kind == 3;
      if (kind == 0) begin
        alu = $urandom;
      end else begin
        alu = 32'($urandom_range(0, 15)) << 2;
        r = $urandom % 8;
        if (r == 0) alu = alu | 32'($urandom_range(1, 3));
        if (r == 1) alu = alu | (32'h1 << $urandom_range(12, 31));
      end
      drive(v, rw, m2r, mw, 5'($urandom_range(0, 7)), alu, $urandom);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
